pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000: first PC loaded after reset release.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0004: redirect target on exception.
REQ-003 clk  in  1: single clock; all state changes on its rising edge.
REQ-004 rst  in  1: asynchronous, active-low reset; rst=0 resets the block immediately, independent of clk. The PC register's active-high reset is driven from !rst at top level.
REQ-005 pc_cur  in  32: current PC register output.
REQ-006 pc_ena  out  1: load enable to the PC register (combinational).
REQ-007 pc_next  out  32: value loaded into the PC register when pc_ena=1 (combinational).
REQ-008 imem_req  out  1 / imem_addr  out  32: fetch request and address (combinational).
REQ-009 imem_ack  in  1 / imem_rdata  in  32: fetch completion and instruction word, valid in the ack cycle.
REQ-010 stall  in  1: downstream not ready; hold PC after the current fetch completes.
REQ-011 halt  in  1: level; park the fetcher without issuing requests.
REQ-012 br_taken  in  1 / br_target  in  32: branch redirect.
REQ-013 jmp  in  1 / jmp_target  in  32: jump redirect.
REQ-014 exc  in  1: exception redirect to EXC_VECTOR.
REQ-015 inst_valid  out  1 / inst  out  32 / inst_pc  out  32: registered fetched instruction and its address.
REQ-016 state  out  2: FSM state for debug; BOOT=0, FETCH=1, STALL=2, HALT=3.

Function
REQ-017 The FSM SHALL have four states: BOOT, FETCH, STALL, HALT.
REQ-018 BOOT: pc_ena=1, pc_next=BOOT_ADDR, imem_req=0; next state FETCH, unconditionally, after one cycle.
REQ-019 FETCH: imem_req=1 and imem_addr=pc_cur; imem_addr SHALL stay stable until imem_ack.
REQ-020 Redirect priority SHALL be exc > jmp > br_taken; each target has bits [1:0] forced to 00.
REQ-021 In FETCH without imem_ack, a redirect SHALL be latched into a pending register, with pc_ena=0.
  - A pending exception is never overwritten.
  - A later exception overwrites a pending jmp or branch.
  - Otherwise the newest redirect wins.
REQ-022 In FETCH with imem_ack and a redirect (pending or same-cycle): pc_ena=1 and pc_next=target.
  - Same-cycle exc beats a pending jmp or branch.
  - Next cycle inst_valid=0: the fetched word is discarded.
  - Pending is cleared; the FSM stays in FETCH.
REQ-023 In FETCH with imem_ack and no redirect: next cycle inst_valid=1, inst=imem_rdata, inst_pc=pc_cur.
  - pc_ena=1 and pc_next=pc_cur+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - Next state: HALT if halt=1, else STALL if stall=1, else FETCH.
REQ-024 An outstanding request SHALL never be abandoned: halt and stall take effect only at imem_ack.
REQ-025 STALL: imem_req=0 and pc_ena=0.
  - A redirect loads its target (pc_ena=1) and moves to FETCH, even if stall=1.
  - Otherwise stall=0 -> FETCH; halt=1 -> HALT, with halt taking precedence over stall.
REQ-026 HALT: imem_req=0.
  - A redirect loads its target immediately (pc_ena=1) and remains in HALT.
  - halt=0 -> FETCH.
REQ-027 inst_valid SHALL be a one-cycle pulse per accepted fetch; inst and inst_pc hold their value otherwise.
REQ-028 Latency: ack at cycle N -> inst_valid at N+1; the next request with the updated pc_cur is issued at N+1.

Reset
REQ-029 While rst=0, the block SHALL hold:
  - state=BOOT; pending redirect cleared.
  - pc_ena=0, pc_next=0, imem_req=0, imem_addr=0.
  - inst_valid=0, inst=0, inst_pc=0.
REQ-030 On the first rising edge after rst returns to 1, the block SHALL execute BOOT.
REQ-031 Reset asserted mid-fetch SHALL drop imem_req at once; any later imem_ack SHALL be ignored until FETCH is re-entered.

Verification
REQ-032 Boot and sequential fetch: release rst, imem_ack always 1 -> pc_next=0 in BOOT, then inst_pc=0, 4, 8 on consecutive inst_valid pulses.
REQ-033 Wait-state redirect: hold ack low 3 cycles, then:
  - pulse jmp (target 32'h100) in cycle 1 -> imem_addr is unchanged during the wait.
  - on ack -> inst_valid=0 and pc_next=32'h100.
REQ-034 Priority and misalignment, checked in the same cycle:
  - exc=1, jmp=1, br_taken=1 -> pc_next=32'h4.
  - br_target=32'h203 alone -> pc_next=32'h200.
REQ-035 Stall and halt:
  - stall=1 at ack of PC 8 -> pc_ena=0 and imem_req=0 while stalled.
  - release stall -> pc_next=32'hC.
  - halt=1 -> no requests until halt=0.
REQ-036 Wrap and reset:
  - PC 32'hFFFF_FFFC with ack -> pc_next=0.
  - rst=0 mid-fetch -> imem_req=0 immediately and all outputs at their reset values.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer that drives an external PC register and an instruction memory port.
// Redirects raised during memory wait states are held until the outstanding fetch completes.
module pc_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        pend_vld_r;
  logic        pend_exc_r;
  logic [31:0] pend_tgt_r;
  logic        pend_vld_nxt_s;
  logic        pend_exc_nxt_s;
  logic [31:0] pend_tgt_nxt_s;
  logic        redir_s;
  logic [31:0] redir_tgt_s;
  logic        merge_vld_s;
  logic        merge_exc_s;
  logic [31:0] merge_tgt_s;
  logic        accept_s;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Resolve same-cycle redirect priority and merge it with any pending redirect.
  always_comb begin
    redir_s     = exc | jmp | br_taken;
    merge_vld_s = pend_vld_r | redir_s;
    merge_exc_s = pend_exc_r | exc;
    if (exc) begin
      redir_tgt_s = word_align(EXC_VECTOR);
    end else if (jmp) begin
      redir_tgt_s = word_align(jmp_target);
    end else if (br_taken) begin
      redir_tgt_s = word_align(br_target);
    end else begin
      redir_tgt_s = 32'h0000_0000;
    end
    // A pending exception is sticky; otherwise the newest redirect wins.
    if (pend_exc_r) begin
      merge_tgt_s = pend_tgt_r;
    end else if (redir_s) begin
      merge_tgt_s = redir_tgt_s;
    end else begin
      merge_tgt_s = pend_tgt_r;
    end
  end

  // Next-state, PC load and memory request decode.
  always_comb begin
    state_nxt_s    = state_r;
    pc_ena         = 1'b0;
    pc_next        = 32'h0000_0000;
    imem_req       = 1'b0;
    imem_addr      = 32'h0000_0000;
    pend_vld_nxt_s = pend_vld_r;
    pend_exc_nxt_s = pend_exc_r;
    pend_tgt_nxt_s = pend_tgt_r;
    accept_s       = 1'b0;
    if (!rst) begin
      state_nxt_s    = BOOT;
      pend_vld_nxt_s = 1'b0;
      pend_exc_nxt_s = 1'b0;
      pend_tgt_nxt_s = 32'h0000_0000;
    end else begin
      pc_next   = pc_cur;
      imem_addr = pc_cur;
      case (state_r)
        BOOT: begin
          pc_ena      = 1'b1;
          pc_next     = BOOT_ADDR;
          state_nxt_s = FETCH;
        end
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            pc_ena         = 1'b1;
            pend_vld_nxt_s = 1'b0;
            pend_exc_nxt_s = 1'b0;
            pend_tgt_nxt_s = 32'h0000_0000;
            if (merge_vld_s) begin
              pc_next     = merge_tgt_s;
              state_nxt_s = FETCH;
            end else begin
              pc_next  = pc_cur + 32'd4;
              accept_s = 1'b1;
              if (halt) begin
                state_nxt_s = HALT;
              end else if (stall) begin
                state_nxt_s = STALL;
              end else begin
                state_nxt_s = FETCH;
              end
            end
          end else begin
            pend_vld_nxt_s = merge_vld_s;
            pend_exc_nxt_s = merge_exc_s;
            pend_tgt_nxt_s = merge_tgt_s;
          end
        end
        STALL: begin
          if (merge_vld_s) begin
            pc_ena      = 1'b1;
            pc_next     = merge_tgt_s;
            state_nxt_s = FETCH;
          end else if (halt) begin
            state_nxt_s = HALT;
          end else if (!stall) begin
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = STALL;
          end
        end
        HALT: begin
          if (merge_vld_s) begin
            pc_ena      = 1'b1;
            pc_next     = merge_tgt_s;
            state_nxt_s = HALT;
          end else if (!halt) begin
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = HALT;
          end
        end
        default: begin
          state_nxt_s = BOOT;
        end
      endcase
    end
  end

  // State, pending redirect and fetched-instruction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= BOOT;
      pend_vld_r <= 1'b0;
      pend_exc_r <= 1'b0;
      pend_tgt_r <= 32'h0000_0000;
      inst_valid <= 1'b0;
      inst       <= 32'h0000_0000;
      inst_pc    <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      pend_vld_r <= pend_vld_nxt_s;
      pend_exc_r <= pend_exc_nxt_s;
      pend_tgt_r <= pend_tgt_nxt_s;
      inst_valid <= accept_s;
      if (accept_s) begin
        inst    <= imem_rdata;
        inst_pc <= pc_cur;
      end
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: external PC register and memory model,
// a scoreboard for fetched instructions, a HALT-mode redirect table and hand sequences.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall, halt, br_taken, jmp, exc;
  logic [31:0] br_target, jmp_target;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic [1:0]  state;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_ena(pc_ena), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .halt(halt), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .exc(exc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .state(state)
  );

  always #5 clk = ~clk;

  // External PC register, reset from !rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_cur <= 32'h0;
    else if (pc_ena) pc_cur <= pc_next;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hA5C3_0F00) + 32'h0000_1111;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    string       name;
    logic        exc;
    logic        jmp;
    logic        br;
    logic [31:0] jt;
    logic [31:0] bt;
    logic        ena;
    logic [31:0] nxt;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = mem_word(pc);
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every inst_valid pulse must match the oldest expected fetch.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && inst_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_inst_valid: got inst_pc %h, expected no instruction", inst_pc);
      end else begin
        e = sb_q.pop_front();
        check("sb_inst_pc", inst_pc, e.pc);
        check("sb_inst", inst, e.word);
      end
    end
  end

  initial begin
    vecs[0] = '{"halt_idle",    1'b0, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 32'h0};
    vecs[1] = '{"prio_all",     1'b1, 1'b1, 1'b1, 32'h100,       32'h200, 1'b1, 32'h4};
    vecs[2] = '{"prio_jmp_br",  1'b0, 1'b1, 1'b1, 32'h103,       32'h200, 1'b1, 32'h100};
    vecs[3] = '{"br_misalign",  1'b0, 1'b0, 1'b1, 32'h0,         32'h203, 1'b1, 32'h200};
    vecs[4] = '{"jmp_misalign", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,   1'b1, 32'hFFFF_FFFC};
    vecs[5] = '{"exc_only",     1'b1, 1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 32'h4};

    rst = 1'b0; imem_ack = 1'b0; stall = 1'b0; halt = 1'b0;
    br_taken = 1'b0; jmp = 1'b0; exc = 1'b0; br_target = 32'h0; jmp_target = 32'h0;

    // Reset state
    repeat (2) cyc();
    smp();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc_ena", 32'(pc_ena), 32'd0);
    check("rst_pc_next", pc_next, 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Boot and sequential fetch with ack held high
    cyc(); rst = 1'b1; imem_ack = 1'b1;
    smp();
    check("boot_state", 32'(state), 32'd0);
    check("boot_pc_ena", 32'(pc_ena), 32'd1);
    check("boot_pc_next", pc_next, 32'h0);
    check("boot_imem_req", 32'(imem_req), 32'd0);
    cyc(); smp();
    check("f0_req", 32'(imem_req), 32'd1);
    check("f0_addr", imem_addr, 32'h0);
    check("f0_pc_next", pc_next, 32'h4);
    push_exp(32'h0);
    cyc(); smp();
    check("f1_addr", imem_addr, 32'h4);
    check("f1_pc_next", pc_next, 32'h8);
    push_exp(32'h4);
    cyc(); stall = 1'b1;
    smp();
    check("f2_addr", imem_addr, 32'h8);
    check("f2_pc_next", pc_next, 32'hC);
    push_exp(32'h8);

    // Stalled: no requests, PC held
    repeat (2) begin
      cyc(); smp();
      check("stall_state", 32'(state), 32'd2);
      check("stall_pc_ena", 32'(pc_ena), 32'd0);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    cyc(); stall = 1'b0;
    smp();
    check("unstall_pc_ena", 32'(pc_ena), 32'd0);
    check("unstall_pc_next", pc_next, 32'hC);
    cyc(); halt = 1'b1;
    smp();
    check("fC_addr", imem_addr, 32'hC);
    check("fC_req", 32'(imem_req), 32'd1);
    push_exp(32'hC);
    cyc(); smp();
    check("halt_state", 32'(state), 32'd3);
    check("halt_req", 32'(imem_req), 32'd0);

    // Redirect priority / alignment table applied while parked in HALT
    for (int i = 0; i < 6; i++) begin
      cyc();
      exc = vecs[i].exc; jmp = vecs[i].jmp; br_taken = vecs[i].br;
      jmp_target = vecs[i].jt; br_target = vecs[i].bt;
      smp();
      check({vecs[i].name, "_state"}, 32'(state), 32'd3);
      check({vecs[i].name, "_req"}, 32'(imem_req), 32'd0);
      check({vecs[i].name, "_ena"}, 32'(pc_ena), 32'(vecs[i].ena));
      if (vecs[i].ena) check({vecs[i].name, "_pc_next"}, pc_next, vecs[i].nxt);
    end

    // Leave HALT at PC 4, then wait-state jump
    cyc(); exc = 1'b0; jmp = 1'b0; br_taken = 1'b0; imem_ack = 1'b0; halt = 1'b0;
    smp();
    check("unhalt_req", 32'(imem_req), 32'd0);
    cyc(); jmp = 1'b1; jmp_target = 32'h100;
    smp();
    check("w1_addr", imem_addr, 32'h4);
    check("w1_pc_ena", 32'(pc_ena), 32'd0);
    check("w1_req", 32'(imem_req), 32'd1);
    cyc(); jmp = 1'b0;
    smp();
    check("w2_addr", imem_addr, 32'h4);
    check("w2_pc_ena", 32'(pc_ena), 32'd0);
    cyc(); smp();
    check("w3_addr", imem_addr, 32'h4);
    cyc(); imem_ack = 1'b1;
    smp();
    check("wack_pc_ena", 32'(pc_ena), 32'd1);
    check("wack_pc_next", pc_next, 32'h100);

    // Pending branch loses to same-cycle exception at ack
    cyc(); imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h300;
    smp();
    check("redir_inst_valid", 32'(inst_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h100);
    cyc(); br_taken = 1'b0; exc = 1'b1; imem_ack = 1'b1;
    smp();
    check("exc_over_br", pc_next, 32'h4);

    // Pending exception survives a later jump
    cyc(); imem_ack = 1'b0;
    smp();
    check("pexc_addr", imem_addr, 32'h4);
    cyc(); exc = 1'b0; jmp = 1'b1; jmp_target = 32'h200;
    smp();
    check("pexc_pc_ena", 32'(pc_ena), 32'd0);
    cyc(); jmp = 1'b0; imem_ack = 1'b1;
    smp();
    check("pexc_sticky", pc_next, 32'h4);

    // Wrap at the top of the address space
    cyc(); jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
    smp();
    check("to_top_pc_next", pc_next, 32'hFFFF_FFFC);
    cyc(); jmp = 1'b0;
    smp();
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc_next", pc_next, 32'h0);
    push_exp(32'hFFFF_FFFC);
    cyc(); imem_ack = 1'b0;
    smp();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", 32'(imem_req), 32'd1);

    // Asynchronous reset mid-fetch
    #2 rst = 1'b0;
    #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_pc_ena", 32'(pc_ena), 32'd0);
    check("arst_pc_next", pc_next, 32'h0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_inst_valid", 32'(inst_valid), 32'd0);
    check("arst_inst", inst, 32'h0);
    check("arst_inst_pc", inst_pc, 32'h0);
    imem_ack = 1'b1;
    repeat (2) begin
      cyc(); smp();
      check("inrst_inst_valid", 32'(inst_valid), 32'd0);
      check("inrst_req", 32'(imem_req), 32'd0);
    end
    cyc(); rst = 1'b1;
    smp();
    check("reboot_state", 32'(state), 32'd0);
    check("reboot_pc_next", pc_next, 32'h0);
    cyc(); smp();
    check("reboot_addr", imem_addr, 32'h0);
    push_exp(32'h0);
    cyc(); imem_ack = 1'b0;
    smp();
    check("reboot_next_addr", imem_addr, 32'h4);
    cyc(); smp();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
